// File: rtl/tt_seq_pkg.sv
// Shared types and constants for the truth-table sequencer.
// The sequencer sweeps 3- or 4-input combinational blocks. These constants set
// how many vectors exist and which index ends a sweep.
package tt_seq_pkg;

    localparam int MAX_IN    = 4;
    localparam int MAX_VEC   = 16;
    localparam int VEC3_LAST = 7;
    localparam int VEC4_LAST = 15;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle timer for the truth-table sequencer.
// A load arms the timer for SETTLE cycles. expire is high during the last of
// those cycles, so the owner leaves its wait state on the following edge.
module tt_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    logic [3:0] count;
    logic       running;

    // Count down from SETTLE-1 after a load, then stop until the next load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= 4'd0;
            running <= 1'b0;
        end else if (load) begin
            count   <= 4'(SETTLE - 1);
            running <= 1'b1;
        end else if (running) begin
            if (count == 4'd0) begin
                running <= 1'b0;
            end else begin
                count <= count - 4'd1;
            end
        end
    end

    assign expire = running && (count == 4'd0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: drives every input vector into a small combinational
// block and captures its Y output. It compares Y against a latched expected
// table and reports the pass flag, the mismatch count, the first failing
// index and the observed table.
// Optional build macro STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module truth_table_sequencer #(
    parameter int SETTLE = 1,
    parameter int MAX_IN = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     n_sel,
    input  logic [(1<<MAX_IN)-1:0]   expected,
    output logic [MAX_IN-1:0]        dut_in,
    input  logic                     dut_y,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [MAX_IN:0]          fail_count,
    output logic [MAX_IN-1:0]        first_fail_idx,
    output logic [(1<<MAX_IN)-1:0]   observed
);

    import tt_seq_pkg::*;

    localparam int VW = 1 << MAX_IN;

    state_t             state;
    logic [MAX_IN-1:0]  idx;
    logic               n_lat;
    logic [VW-1:0]      exp_lat;
    logic [MAX_IN-1:0]  last_idx;
    logic               mismatch;
    logic               stop_now;
    logic               at_end;
    logic               settle_load;
    logic               settle_expire;

    // Work out the final index, the mismatch and the early stop for this sample.
    // Also decide when the settle timer must be re-armed.
    always_comb begin
        last_idx    = n_lat ? MAX_IN'(VEC4_LAST) : MAX_IN'(VEC3_LAST);
        mismatch    = (dut_y != exp_lat[idx]);
`ifdef STOP_ON_FAIL_EN
        stop_now    = mismatch;
`else
        stop_now    = 1'b0;
`endif
        at_end      = (idx == last_idx) || stop_now;
        settle_load = ((state == IDLE) && start) ||
                      ((state == SAMPLE) && !at_end);
    end

    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk    (clk),
        .reset  (reset),
        .load   (settle_load),
        .expire (settle_expire)
    );

    // Sweep controller: latch the request, step through the vectors, score
    // each sample, then pulse done and publish pass
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            n_lat          <= 1'b0;
            exp_lat        <= '0;
            dut_in         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            observed       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done   <= 1'b0;
                    dut_in <= '0;
                    if (start) begin
                        n_lat          <= n_sel;
                        exp_lat        <= expected;
                        observed       <= '0;
                        fail_count     <= '0;
                        first_fail_idx <= '0;
                        pass           <= 1'b0;
                        idx            <= '0;
                        busy           <= 1'b1;
                        state          <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_expire) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    observed[idx] <= dut_y;
                    if (mismatch) begin
                        fail_count <= fail_count + 1'b1;
                        if (fail_count == '0) begin
                            first_fail_idx <= idx;
                        end
                    end
                    if (at_end) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        idx    <= idx + 1'b1;
                        dut_in <= idx + 1'b1;
                        state  <= DRIVE;
                    end
                end
                DONE: begin
                    done   <= 1'b1;
                    pass   <= (fail_count == '0);
                    dut_in <= '0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench for truth_table_sequencer.
// Two instances, with SETTLE=1 and SETTLE=3, share the clock, reset and
// request inputs. The Y of each instance comes from a selectable reference
// function of its own dut_in. Expected results come from a per-sweep model
// built from the sweep rules.
module tb_truth_table_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  start;
    logic        n_sel;
    logic [15:0] expected;

    logic [3:0]  dut_in_w [2];
    logic        dut_y_w  [2];
    logic        busy_w   [2];
    logic        done_w   [2];
    logic        pass_w   [2];
    logic [4:0]  fc_w     [2];
    logic [3:0]  ffi_w    [2];
    logic [15:0] obs_w    [2];

    int          errors = 0;
    int          checks = 0;
    int          mode;
    logic [15:0] rand_table;

    always #5 clk = ~clk;

    // Unit-under-test functions: (A&B)|C, 4-bit parity, constant 0, random table
    function automatic logic model_y(input logic [3:0] v, input int m, input logic [15:0] t);
        case (m)
            0:       return (v[2] & v[1]) | v[0];
            1:       return ^v;
            2:       return 1'b0;
            default: return t[v];
        endcase
    endfunction

    assign dut_y_w[0] = model_y(dut_in_w[0], mode, rand_table);
    assign dut_y_w[1] = model_y(dut_in_w[1], mode, rand_table);

    truth_table_sequencer #(.SETTLE(1), .MAX_IN(4)) u_dut_s1 (
        .clk            (clk),
        .reset          (reset),
        .start          (start[0]),
        .n_sel          (n_sel),
        .expected       (expected),
        .dut_in         (dut_in_w[0]),
        .dut_y          (dut_y_w[0]),
        .busy           (busy_w[0]),
        .done           (done_w[0]),
        .pass           (pass_w[0]),
        .fail_count     (fc_w[0]),
        .first_fail_idx (ffi_w[0]),
        .observed       (obs_w[0])
    );

    truth_table_sequencer #(.SETTLE(3), .MAX_IN(4)) u_dut_s3 (
        .clk            (clk),
        .reset          (reset),
        .start          (start[1]),
        .n_sel          (n_sel),
        .expected       (expected),
        .dut_in         (dut_in_w[1]),
        .dut_y          (dut_y_w[1]),
        .busy           (busy_w[1]),
        .done           (done_w[1]),
        .pass           (pass_w[1]),
        .fail_count     (fc_w[1]),
        .first_fail_idx (ffi_w[1]),
        .observed       (obs_w[1])
    );

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outputs(input int k);
        return {dut_in_w[k], busy_w[k], done_w[k], pass_w[k], fc_w[k], ffi_w[k], obs_w[k]};
    endfunction

    // One complete sweep on instance inst.
    // glitch_at: edge at which start is re-pulsed and the request inputs disturbed.
    // reset_at: edge at which reset is asserted.
    task automatic apply_stimulus(input int inst, input logic nsel, input logic [15:0] exp,
                                  input int glitch_at, input int reset_at);
        int          settle;
        int          nvec;
        int          swept;
        int          m_fail;
        int          m_first;
        logic [15:0] m_obs;
        logic        y;
        int          lat;
        int          c;
        int          done_edge;
        int          seq_err;

        settle  = (inst == 0) ? 1 : 3;
        nvec    = nsel ? 16 : 8;
        swept   = nvec;
        m_fail  = 0;
        m_first = 0;
        m_obs   = 16'h0;
        for (int i = 0; i < nvec; i++) begin
            y = model_y(4'(i), mode, rand_table);
            m_obs[i] = y;
            if (y != exp[i]) begin
                if (m_fail == 0) m_first = i;
                m_fail++;
`ifdef STOP_ON_FAIL_EN
                swept = i + 1;
                break;
`endif
            end
        end
        lat = 1 + swept * (settle + 1);

        @(negedge clk);
        n_sel       = nsel;
        expected    = exp;
        start[inst] = 1'b1;
        @(posedge clk);
        #1;
        start[inst] = 1'b0;

        c         = 0;
        done_edge = -1;
        seq_err   = 0;
        while (c < lat + 40 && done_edge < 0) begin
            if (c == reset_at) begin
                reset = 1'b1;
                #1;
                check_output("reset_mid_sweep_outputs", all_outputs(inst), 32'h0);
                @(posedge clk);
                #1;
                check_output("reset_no_done", {31'h0, done_w[inst]}, 32'h0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (c < swept * (settle + 1)) begin
                if (busy_w[inst] !== 1'b1 || int'(dut_in_w[inst]) != c / (settle + 1)) seq_err++;
            end
            if (c == glitch_at) begin
                start[inst] = 1'b1;
                expected    = ~exp;
                n_sel       = ~nsel;
            end else if (c == glitch_at + 1) begin
                start[inst] = 1'b0;
            end
            if (done_w[inst] === 1'b1) begin
                done_edge = c;
            end else begin
                @(posedge clk);
                #1;
                c++;
            end
        end
        start[inst] = 1'b0;

        check_output("done_latency", 32'(done_edge), 32'(lat));
        check_output("dut_in_sequence_errors", 32'(seq_err), 32'h0);
        check_output("pass", {31'h0, pass_w[inst]}, {31'h0, m_fail == 0});
        check_output("fail_count", {27'h0, fc_w[inst]}, 32'(m_fail));
        check_output("first_fail_idx", {28'h0, ffi_w[inst]}, 32'(m_first));
        check_output("observed", {16'h0, obs_w[inst]}, {16'h0, m_obs});
        @(posedge clk);
        #1;
        check_output("after_done_idle", {27'h0, done_w[inst], busy_w[inst], dut_in_w[inst]}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        start      = 2'b00;
        n_sel      = 1'b0;
        expected   = 16'h0;
        mode       = 0;
        rand_table = 16'h0;
        @(posedge clk);
        #1;
        check_output("reset_state_s1", all_outputs(0), 32'h0);
        check_output("reset_state_s3", all_outputs(1), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] 3-input (A&B)|C sweeps");
        mode = 0;
        apply_stimulus(0, 1'b0, 16'h00EA, -1, -1);
        apply_stimulus(0, 1'b0, 16'h00EB, -1, -1);
        apply_stimulus(1, 1'b0, 16'hFF6A, -1, -1);

        $display("[TB] 4-input parity sweeps");
        mode = 1;
        apply_stimulus(1, 1'b1, 16'h6996, -1, -1);
        apply_stimulus(0, 1'b1, 16'h6996, -1, -1);

        $display("[TB] Y tied low");
        mode = 2;
        apply_stimulus(1, 1'b1, 16'h8001, -1, -1);
        apply_stimulus(0, 1'b1, 16'h8000, -1, -1);
        apply_stimulus(0, 1'b1, 16'hFFFF, -1, -1);

        $display("[TB] reset at vector 5, then fresh sweep");
        mode = 1;
        apply_stimulus(1, 1'b1, 16'h6996, -1, 21);
        apply_stimulus(1, 1'b1, 16'h6996, -1, -1);

        $display("[TB] start and table changes mid-sweep");
        mode = 0;
        apply_stimulus(0, 1'b0, 16'h00EA, 6, -1);
        mode = 1;
        apply_stimulus(1, 1'b1, 16'h6990, 12, -1);

        $display("[TB] randomized sweeps");
        mode = 3;
        for (int r = 0; r < 12; r++) begin
            logic [15:0] ex;
            rand_table = 16'($urandom);
            if ($urandom_range(0, 2) == 0) ex = rand_table;
            else ex = rand_table ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            apply_stimulus(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ex, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
